// File: rtl/cache_controller.sv
// Cache controller: sequences CPU loads/stores against an external cache store
// and a backing SRAM. Only the FSM state is registered; outputs are combinational.
module cache_controller #(
  parameter int TAG_W   = 10,
  parameter int INDEX_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [31:0]        sram_address,
  output logic [31:0]        sram_wdata,
  output logic               sram_read,
  output logic               sram_write,
  input  logic [63:0]        sram_rdata,
  input  logic               sram_ready,
  output logic               cache_r_en,
  output logic               cache_w_en,
  output logic [TAG_W-1:0]   cache_tag,
  output logic [INDEX_W-1:0] cache_index,
  output logic [63:0]        cache_data,
  input  logic [63:0]        cache_data_in,
  input  logic               cache_hit
);

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_t;
  state_t state;

  logic word_sel;

  assign word_sel    = address[2];
  assign cache_index = address[3 +: INDEX_W];
  assign cache_tag   = address[3+INDEX_W +: TAG_W];
  assign cache_data  = sram_rdata;
  assign sram_wdata  = wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_W_EN)
            state <= WRITE_WAIT;
          else if (MEM_R_EN && !cache_hit)
            state <= READ_WAIT;
        end
        READ_WAIT, WRITE_WAIT: begin
          if (sram_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ready        = 1'b0;
    rdata        = '0;
    sram_read    = 1'b0;
    sram_write   = 1'b0;
    cache_r_en   = 1'b0;
    cache_w_en   = 1'b0;
    sram_address = {address[31:3], 3'b000};
    case (state)
      IDLE: begin
        // Stores win over loads; sram_ready is deliberately ignored here.
        if (MEM_W_EN) begin
          cache_w_en   = 1'b1;
          sram_write   = 1'b1;
          sram_address = address;
        end else if (MEM_R_EN) begin
          if (cache_hit) begin
            ready = 1'b1;
            rdata = word_sel ? cache_data_in[63:32] : cache_data_in[31:0];
          end else begin
            sram_read = 1'b1;
          end
        end else begin
          ready = 1'b1;
        end
      end
      READ_WAIT: begin
        sram_read = 1'b1;
        if (sram_ready) begin
          cache_r_en = 1'b1;
          ready      = 1'b1;
          rdata      = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
        end
      end
      WRITE_WAIT: begin
        sram_write   = 1'b1;
        sram_address = address;
        if (sram_ready) ready = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller with a transaction-level model of the
// cache store and backing memory kept inside the bench.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
  logic        MEM_R_EN, MEM_W_EN, ready, sram_read, sram_write, sram_ready;
  logic [63:0] sram_rdata, cache_data, cache_data_in;
  logic        cache_r_en, cache_w_en, cache_hit;
  logic [9:0]  cache_tag;
  logic [5:0]  cache_index;

  always #5 clk = ~clk;

  cache_controller #(.TAG_W(10), .INDEX_W(6)) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_read(sram_read), .sram_write(sram_write),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .cache_r_en(cache_r_en), .cache_w_en(cache_w_en),
    .cache_tag(cache_tag), .cache_index(cache_index),
    .cache_data(cache_data), .cache_data_in(cache_data_in),
    .cache_hit(cache_hit)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: backing memory lines keyed by address[31:3], and the
  // contents the cache store would hold per set.
  bit [63:0] mem [bit [28:0]];
  bit        cvalid [64];
  bit [9:0]  ctag   [64];
  bit [63:0] cline  [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [63:0] mem_line(input bit [28:0] la);
    if (mem.exists(la)) return mem[la];
    return {3'b000, la, 3'b000, la} ^ 64'h5A5A_0F0F_C3C3_9696;
  endfunction

  function automatic bit [31:0] pick(input bit [63:0] l, input bit s);
    return s ? l[63:32] : l[31:0];
  endfunction

  function automatic bit [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"},   ready, 1);
    check({tag, "_strobes"}, {sram_read, sram_write, cache_r_en, cache_w_en}, 0);
    check({tag, "_rdata"},   rdata, 0);
  endtask

  task automatic do_idle();
    @(negedge clk);
    MEM_R_EN = 0; MEM_W_EN = 0;
    sram_ready = 1'($urandom % 2);
    sram_rdata = rnd64();
    cache_hit = 1'($urandom % 2);
    #1 check_idle("idle");
  endtask

  // w = number of SRAM wait cycles between the issue cycle and the completion cycle
  task automatic do_read(input bit [31:0] a, input int unsigned w);
    bit [5:0]  idx = a[8:3];
    bit [9:0]  tg  = a[18:9];
    bit        hit = cvalid[idx] && (ctag[idx] == tg);
    bit [63:0] line;
    @(negedge clk);
    address = a; MEM_R_EN = 1; MEM_W_EN = 0;
    sram_ready = 1'($urandom % 2);
    cache_hit = hit;
    cache_data_in = hit ? cline[idx] : rnd64();
    #1;
    check("rd_tag", cache_tag, tg);
    check("rd_index", cache_index, idx);
    if (hit) begin
      check("hit_ready", ready, 1);
      check("hit_rdata", rdata, pick(cline[idx], a[2]));
      check("hit_sram_read", sram_read, 0);
      check("hit_fill", cache_r_en, 0);
      return;
    end
    check("miss_ready", ready, 0);
    check("miss_sram_read", sram_read, 1);
    check("miss_rdata", rdata, 0);
    check("miss_sram_addr", sram_address, {a[31:3], 3'b000});
    for (int unsigned i = 0; i < w; i++) begin
      @(negedge clk);
      sram_ready = 0; sram_rdata = rnd64(); cache_hit = 1'($urandom % 2);
      #1;
      check("rwait_ready", ready, 0);
      check("rwait_sram_read", sram_read, 1);
      check("rwait_fill", cache_r_en, 0);
      check("rwait_rdata", rdata, 0);
    end
    line = mem_line(a[31:3]);
    @(negedge clk);
    sram_ready = 1; sram_rdata = line;
    #1;
    check("fill_ready", ready, 1);
    check("fill_rdata", rdata, pick(line, a[2]));
    check("fill_strobe", cache_r_en, 1);
    check("fill_data", cache_data, line);
    check("fill_index", cache_index, idx);
    cvalid[idx] = 1; ctag[idx] = tg; cline[idx] = line;
  endtask

  task automatic do_write(input bit [31:0] a, input bit [31:0] d, input int unsigned w, input bit both);
    bit [5:0]  idx = a[8:3];
    bit [63:0] line;
    @(negedge clk);
    address = a; wdata = d; MEM_W_EN = 1; MEM_R_EN = both;
    sram_ready = 1'($urandom % 2); cache_hit = 1'($urandom % 2);
    #1;
    check("wr_inval", cache_w_en, 1);
    check("wr_sram_write", sram_write, 1);
    check("wr_sram_read", sram_read, 0);
    check("wr_ready", ready, 0);
    check("wr_sram_addr", sram_address, a);
    check("wr_sram_wdata", sram_wdata, d);
    check("wr_tag", cache_tag, a[18:9]);
    check("wr_index", cache_index, idx);
    for (int unsigned i = 0; i < w; i++) begin
      @(negedge clk);
      sram_ready = 0;
      #1;
      check("wwait_sram_write", sram_write, 1);
      check("wwait_inval", cache_w_en, 0);
      check("wwait_ready", ready, 0);
      check("wwait_sram_read", sram_read, 0);
    end
    @(negedge clk);
    sram_ready = 1;
    #1;
    check("wdone_ready", ready, 1);
    check("wdone_inval", cache_w_en, 0);
    check("wdone_rdata", rdata, 0);
    check("wdone_fill", cache_r_en, 0);
    cvalid[idx] = 0;
    line = mem_line(a[31:3]);
    if (a[2]) line[63:32] = d; else line[31:0] = d;
    mem[a[31:3]] = line;
  endtask

  // Issue a miss or a store, then reset mid-access; the access must vanish.
  task automatic do_abort(input bit [31:0] a, input bit is_write);
    @(negedge clk);
    address = a; wdata = $urandom;
    MEM_R_EN = !is_write; MEM_W_EN = is_write;
    cache_hit = 0; sram_ready = 0;
    @(negedge clk);
    sram_ready = 0;
    #1 check("abort_busy", ready, 0);
    @(negedge clk);
    MEM_R_EN = 0; MEM_W_EN = 0; sram_ready = 0;
    rst = 1;
    #1;
    check("abort_rst_strobes", {sram_read, sram_write, cache_r_en}, 0);
    check("abort_rst_ready", ready, 1);
    #1 rst = 0;
    @(negedge clk);
    sram_ready = 1; sram_rdata = rnd64();
    #1;
    check("abort_no_fill", cache_r_en, 0);
    check_idle("abort_after");
    if (is_write) cvalid[a[8:3]] = 0;
  endtask

  function automatic bit [31:0] rnd_addr();
    bit [31:0] a = $urandom;
    a[18:9] = 10'($urandom_range(0, 2));
    a[8:3]  = 6'($urandom_range(0, 3));
    return a;
  endfunction

  initial begin
    rst = 1; address = 0; wdata = 0; MEM_R_EN = 0; MEM_W_EN = 0;
    sram_rdata = 0; sram_ready = 0; cache_data_in = 0; cache_hit = 0;
    for (int i = 0; i < 64; i++) cvalid[i] = 0;
    #1 check_idle("reset");
    @(negedge clk);
    #1 check_idle("reset_held");
    rst = 0;

    // Directed: miss with two wait cycles, hit on the other word, store.
    mem[29'(32'h0000_0108 >> 3)] = 64'hAAAA_BBBB_1111_2222;
    do_read(32'h0000_0108, 2);
    do_idle();
    do_read(32'h0000_010C, 0);
    check("hit_upper_word", rdata, 32'hAAAA_BBBB);
    do_write(32'h0000_0200, 32'hDEAD_BEEF, 2, 0);
    do_write(32'h0000_0204, 32'h1234_5678, 0, 1);
    do_idle();
    do_abort(32'h0000_0308, 0);
    do_abort(32'h0000_0410, 1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    do_idle();
        2, 3, 4, 5: do_read(rnd_addr(), $urandom_range(0, 3));
        6, 7:    do_write(rnd_addr(), $urandom, $urandom_range(0, 3), 0);
        8:       do_write(rnd_addr(), $urandom, $urandom_range(0, 3), 1);
        default: do_abort(rnd_addr(), 1'($urandom % 2));
      endcase
    end
    do_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
